// File: rtl/x_cfglut_pkg.sv
// Shared constants and the X-pessimism-reducing table read for the reloadable LUT.
package x_cfglut_pkg;

    localparam int KMAX = 6;
    localparam int NMAX = 64;

    localparam logic [0:0] ST_READY = 1'b0;
    localparam logic [0:0] ST_LOAD  = 1'b1;

    // 2:1 select that resolves an unknown select when both data inputs agree.
    function automatic logic xmux2(input logic a, input logic b, input logic s);
        if (s === 1'b0)
            return a;
        else if (s === 1'b1)
            return b;
        else
            return (a === b) ? a : 1'bx;
    endfunction

    // Binary reduction tree, LSB address bit first; entries above 2**k are ignored.
    function automatic logic lut_read(input logic [NMAX-1:0] tbl,
                                      input logic [KMAX-1:0] adr,
                                      input int k);
        logic [NMAX-1:0] v;
        v = tbl;
        for (int lvl = 0; lvl < KMAX; lvl++) begin
            if (lvl < k) begin
                for (int j = 0; j < NMAX / 2; j++)
                    v[j] = xmux2(v[2*j], v[2*j+1], adr[lvl]);
            end
        end
        return v[0];
    endfunction

endpackage

// File: rtl/x_lut_xmux.sv
// Combinational X-aware read of a 2**K entry table.
module x_lut_xmux
    import x_cfglut_pkg::*;
#(
    parameter int K = 5
) (
    input  logic [(1<<K)-1:0] tbl,
    input  logic [K-1:0]      adr,
    output logic              o
);

    logic [NMAX-1:0] tbl_ext;
    logic [KMAX-1:0] adr_ext;

    always_comb begin
        tbl_ext = '0;
        adr_ext = '0;
        tbl_ext[(1<<K)-1:0] = tbl;
        adr_ext[K-1:0]      = adr;
        o = lut_read(tbl_ext, adr_ext, K);
    end

endmodule

// File: rtl/x_cfglut_n.sv
// K-input LUT with a serially reloadable truth table (CDI -> table -> CDO chain).
// Define X_CFGLUT_OREG_EN to register O; by default O is combinational.
module x_cfglut_n
    import x_cfglut_pkg::*;
#(
    parameter int          K    = 5,
    parameter logic [63:0] INIT = 64'h0,
    parameter string       LOC  = "UNPLACED"
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CE,
    input  logic         CDI,
    input  logic [K-1:0] ADR,
    output logic         O,
    output logic         CDO,
    output logic         CFG_BUSY,
    output logic         CFG_DONE
);

    localparam int           N        = 1 << K;
    localparam logic [N-1:0] INIT_N   = INIT[N-1:0];
    localparam logic [K:0]   CNT_LAST = (K+1)'(N - 1);

    logic [N-1:0] tbl;
    logic [0:0]   state;
    logic [K:0]   cnt;
    logic         done_q;
    logic         cdi_s;
    logic         lut_o;

    // XOR with 0 turns a floating CDI into X so Z never lands in the table.
    assign cdi_s = CDI ^ 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tbl    <= INIT_N;
            state  <= ST_READY;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (CE) begin
                tbl <= {tbl[N-2:0], cdi_s};
                if (state == ST_READY) begin
                    state <= ST_LOAD;
                    cnt   <= (K+1)'(1);
                end else if (cnt == CNT_LAST) begin
                    state  <= ST_READY;
                    cnt    <= '0;
                    done_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    x_lut_xmux #(.K(K)) u_xmux (
        .tbl (tbl),
        .adr (ADR),
        .o   (lut_o)
    );

`ifdef X_CFGLUT_OREG_EN
    logic o_q;
    always_ff @(posedge CLK) begin
        if (RST)
            o_q <= 1'b0;
        else
            o_q <= lut_o;
    end
    assign O = o_q;
`else
    assign O = lut_o;
`endif

    assign CDO      = tbl[N-1];
    assign CFG_BUSY = (state == ST_LOAD);
    assign CFG_DONE = done_q;

endmodule

// File: tb/tb_x_cfglut_n.sv
// Directed bench for x_cfglut_n at K=5, K=4 and K=3.
module tb_x_cfglut_n;

`ifdef X_CFGLUT_OREG_EN
    localparam bit OREG = 1'b1;
`else
    localparam bit OREG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst5, ce5, cdi5, o5, cdo5, busy5, done5;
    logic [4:0] adr5;
    logic       rst4, ce4, cdi4, o4, cdo4, busy4, done4;
    logic [3:0] adr4;
    logic       rst3, ce3, cdi3, o3, cdo3, busy3, done3;
    logic [2:0] adr3;

    x_cfglut_n #(.K(5), .INIT(64'hA5A5_0F0F), .LOC("X0Y0")) u5 (
        .CLK(clk), .RST(rst5), .CE(ce5), .CDI(cdi5), .ADR(adr5),
        .O(o5), .CDO(cdo5), .CFG_BUSY(busy5), .CFG_DONE(done5));

    x_cfglut_n #(.K(4), .INIT(64'h1234)) u4 (
        .CLK(clk), .RST(rst4), .CE(ce4), .CDI(cdi4), .ADR(adr4),
        .O(o4), .CDO(cdo4), .CFG_BUSY(busy4), .CFG_DONE(done4));

    x_cfglut_n #(.K(3), .INIT(64'hF0)) u3 (
        .CLK(clk), .RST(rst3), .CE(ce3), .CDI(cdi3), .ADR(adr3),
        .O(o3), .CDO(cdo3), .CFG_BUSY(busy3), .CFG_DONE(done3));

    int errors = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] init5;
    logic [15:0] pat2, pat3;
    logic        probe;
    bit          four_state;
    int          busy_cnt, done_cnt, done_at, bi;

    initial begin
        init5 = 32'hA5A5_0F0F;
        pat2  = 16'h8001;
        pat3  = 16'h3C5A;
        probe = 1'bx;
        four_state = $isunknown(probe);

        rst5 = 1; ce5 = 0; cdi5 = 0; adr5 = '0;
        rst4 = 1; ce4 = 0; cdi4 = 0; adr4 = '0;
        rst3 = 1; ce3 = 0; cdi3 = 0; adr3 = '0;
        tick;

        // 1: reset state and full read sweep of INIT
        chk("rst_busy", 64'(busy5), 64'd0);
        chk("rst_done", 64'(done5), 64'd0);
        chk("rst_cdo",  64'(cdo5),  64'd1);
        chk("rst_o",    64'(o5),    OREG ? 64'd0 : 64'd1);
        rst5 = 0; rst4 = 0; rst3 = 0;
        for (int a = 0; a < 32; a++) begin
            adr5 = 5'(a);
            tick;
            chk($sformatf("t1_o[%0d]", a), 64'(o5), 64'(init5[a]));
        end

        // 2: contiguous 16-bit reload
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 16; i++) begin
            ce4 = 1; cdi4 = pat2[15-i];
            tick;
            busy_cnt += int'(busy4);
            if (done4) begin done_cnt++; done_at = i; end
        end
        ce4 = 0;
        tick;
        if (done4) done_cnt++;
        chk("t2_busy_cycles", 64'(busy_cnt), 64'd15);
        chk("t2_done_at",     64'(done_at),  64'd15);
        chk("t2_done_cnt",    64'(done_cnt), 64'd1);
        chk("t2_cdo",         64'(cdo4),     64'd1);
        adr4 = 4'd0;  tick; chk("t2_o0",  64'(o4), 64'd1);
        adr4 = 4'd15; tick; chk("t2_o15", 64'(o4), 64'd1);
        adr4 = 4'd7;  tick; chk("t2_o7",  64'(o4), 64'd0);

        // 3: reload with CE toggling, pauses must hold the count
        busy_cnt = 0; done_cnt = 0; done_at = -1; bi = 15;
        for (int c = 0; c < 32; c++) begin
            ce4 = (c % 2 == 0);
            if (ce4) begin cdi4 = pat3[bi]; bi--; end
            tick;
            busy_cnt += int'(busy4);
            if (done4) begin done_cnt++; done_at = c; end
        end
        ce4 = 0;
        chk("t3_busy_cycles", 64'(busy_cnt), 64'd30);
        chk("t3_done_at",     64'(done_at),  64'd30);
        chk("t3_done_cnt",    64'(done_cnt), 64'd1);
        for (int a = 0; a < 16; a++) begin
            adr4 = 4'(a);
            tick;
            chk($sformatf("t3_o[%0d]", a), 64'(o4), 64'(pat3[a]));
        end

        // 4: partial reload aborted by reset
        for (int i = 0; i < 8; i++) begin
            ce5 = 1; cdi5 = 1;
            tick;
        end
        ce5 = 0;
        chk("t4_busy_mid", 64'(busy5), 64'd1);
        adr5 = 5'd4;
        tick;
        chk("t4_o_partial", 64'(o5), 64'd1);
        rst5 = 1; ce5 = 1;
        tick;
        rst5 = 0; ce5 = 0;
        chk("t4_busy_rst", 64'(busy5), 64'd0);
        chk("t4_done_rst", 64'(done5), 64'd0);
        chk("t4_cdo_rst",  64'(cdo5),  64'd1);
        tick;
        chk("t4_done_after", 64'(done5), 64'd0);
        for (int a = 0; a < 32; a++) begin
            adr5 = 5'(a);
            tick;
            chk($sformatf("t4_o[%0d]", a), 64'(o5), 64'(init5[a]));
        end

        // 5: K=3 reads, including X addresses where the simulator carries X
        adr3 = 3'b100; tick; chk("t5_o4", 64'(o3), 64'd1);
        adr3 = 3'b000; tick; chk("t5_o0", 64'(o3), 64'd0);
        if (four_state) begin
            adr3 = 3'bx00; tick; chk("t5_x00", 64'(o3), 64'(1'bx));
            adr3 = 3'b1x0; tick; chk("t5_1x0", 64'(o3), 64'd1);
        end

        // 6: output latency on an address step
        adr3 = 3'b000;
        tick;
        adr3 = 3'b100;
        #1;
        chk("t6_o_same", 64'(o3), OREG ? 64'd0 : 64'd1);
        tick;
        chk("t6_o_next", 64'(o3), 64'd1);

        // 5 (cont.): all-ones table resolves for any address
        for (int i = 0; i < 8; i++) begin
            ce3 = 1; cdi3 = 1;
            tick;
        end
        ce3 = 0;
        chk("t5_done_ff", 64'(done3), 64'd1);
        adr3 = 3'b010; tick; chk("t5_ff_o2", 64'(o3), 64'd1);
        if (four_state) begin
            adr3 = 3'bxxx; tick; chk("t5_ff_xxx", 64'(o3), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, n_chk);
        $finish;
    end

endmodule
